sprite_plotter: RTL
===================

// Module: sprite_plotter
// PURPOSE
//  Sequencer between the rock/scissor/paper sprite ROMs and vga_adapter.
//  On a start pulse it scans one SPR_W x SPR_H sprite at origin (x0,y0) and drives the sprite ROM address.
//  It delays coordinates to match ROM read latency, decodes the ROM bit to a colour, and drives x/y/colour/plot into vga_adapter.
//  It pulses done when finished, so the game FSM can draw the user half and then the computer half back to back.
// PARAMETERS
//  SPR_W   80  sprite width in pixels (columns per row)
//  SPR_H   120 sprite height in pixels (rows)
//  ADDR_W  15  sprite ROM address width
//  ROM_LAT 1   ROM read latency in clocks (address to q); must be >=1
// PORTS
//  CLOCK_50  in  1       system clock, 50 MHz
//  reset_n   in  1       asynchronous active-low reset
//  start     in  1       request a draw; sampled only in IDLE
//  x0        in  8       sprite origin column on the 160x120 screen
//  y0        in  7       sprite origin row on the 160x120 screen
//  sel       in  2       00 rock, 01 scissor, 10/11 paper
//  player    in  1       0 user (black background), 1 computer (white background)
//  rom_addr  out ADDR_W  shared address to the three sprite ROMs
//  rom_q_r   in  1       rock ROM data (1 = background)
//  rom_q_s   in  1       scissor ROM data
//  rom_q_p   in  1       paper ROM data
//  x         out 8       pixel column to vga_adapter
//  y         out 7       pixel row to vga_adapter
//  colour    out 3       pixel colour to vga_adapter
//  plot      out 1       write enable to vga_adapter
//  busy      out 1       high whenever state != IDLE
//  done      out 1       one-cycle completion pulse
// BEHAVIOUR
//  Reset (async, any time, including mid-scan):
//   - state=IDLE; counters, latched inputs and the delay line are cleared.
//   - rom_addr, x, y, colour, plot, busy and done are all 0.
//  FSM states: IDLE, SCAN, FLUSH, DONE.
//   - IDLE->SCAN on start. Latch x0, y0, sel, player. Clear col, row and rom_addr.
//     start is ignored in SCAN, FLUSH and DONE.
//   - SCAN: one address per clock, rom_addr = row*SPR_W + col, built by increment only (no multiplier).
//     col wraps SPR_W-1->0 and row increments on that wrap.
//     After (col,row) = (SPR_W-1, SPR_H-1) is issued, go to FLUSH.
//   - FLUSH: stays exactly ROM_LAT clocks to drain the delay line, then go to DONE.
//   - DONE: done=1 for one clock, then return to IDLE.
//     A start seen in DONE is dropped; it must be re-asserted in IDLE.
//  Delay line (ROM_LAT stages): carries valid, sx = x0+col, sy = y0+row, and an inbounds flag.
//   - sx is computed 9 bits wide, sy 8 bits wide; inbounds = (sx<160) && (sy<120).
//   - Tail outputs: x=sx[7:0], y=sy[6:0], plot = valid && inbounds.
//   - Out-of-screen pixels are scanned but never plotted (clip, no wrap).
//  Colour (combinational from the tail and the latched sel):
//   - q = selected rom_q_*.
//   - q=0 gives 3'b010 (green sprite).
//   - q=1 gives 3'b000 if player=0, 3'b111 if player=1.
//  Latency: first plot ROM_LAT+1 clocks after the start edge.
//   busy is high for SPR_W*SPR_H + ROM_LAT + 1 clocks (9602 at defaults).
//  Throughput: 1 pixel/clock, no stalls; vga_adapter accepts every plot.
// CONFIGURATION
//  SPRITE_TRANSPARENT_EN
//   - Defined: pixels with q=1 get plot=0, so the sprite overlays the existing framebuffer.
//   - Undefined: every in-bounds pixel is plotted with the background colour rule above.
// STRUCTURE
//  rps_pkg holds:
//   - SCR_W=160 and SCR_H=120
//   - sel encodings SEL_ROCK=2'b00, SEL_SCISSOR=2'b01, SEL_PAPER=2'b10
//   - colour constants COL_SPRITE=3'b010, COL_BG_USER=3'b000, COL_BG_CPU=3'b111
//   - the FSM state enum
//  Sub-module rps_delay_line: parameterised ROM_LAT-deep register chain, async clear, width parameter.
// TESTING
//  - Defaults, start with x0=0, y0=0, sel=00, player=0, ROM model all 0 (lat 1)
//    -> 9600 plots with colour=010; last plot x=79, y=119; done exactly 1 clock; busy 9602 clocks.
//  - x0=80, y0=0, player=1, ROM q=1 everywhere (transparent undefined)
//    -> all plots colour=111; first plot (80,0); last plot (159,119).
//  - x0=120, y0=100 -> plot only where x<160 and y<120 (40x20 = 800 plots); no wrap to x<120 or y<100.
//  - Assert reset_n=0 at pixel 5000, then release and start again
//    -> outputs 0 during reset; new scan restarts at rom_addr=0; exactly one done.
//  - start held high through SCAN and DONE -> exactly one draw per IDLE entry; busy drops 1 clock between draws.
//  - With SPRITE_TRANSPARENT_EN, a checkerboard ROM -> plot only on q=0 pixels (4800 plots).

Source files
------------

// File: rtl/rps_pkg.sv
// Shared constants and FSM state type for the rock/scissor/paper sprite plotter.
package rps_pkg;

  localparam int unsigned SCR_W = 160;
  localparam int unsigned SCR_H = 120;

  localparam logic [1:0] SEL_ROCK    = 2'b00;
  localparam logic [1:0] SEL_SCISSOR = 2'b01;
  localparam logic [1:0] SEL_PAPER   = 2'b10;

  localparam logic [2:0] COL_SPRITE  = 3'b010;
  localparam logic [2:0] COL_BG_USER = 3'b000;
  localparam logic [2:0] COL_BG_CPU  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/rps_delay_line.sv
// LAT-deep register chain of width W with asynchronous active-low clear.
module rps_delay_line #(
  parameter int unsigned LAT = 1,
  parameter int unsigned W   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] pipe [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int unsigned i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[LAT-1];

endmodule

// File: rtl/sprite_plotter.sv
// Scans one sprite ROM and feeds clipped, coloured pixels to vga_adapter.
// Optional: define SPRITE_TRANSPARENT_EN to skip plotting background (q=1) pixels.
module sprite_plotter
  import rps_pkg::*;
#(
  parameter int unsigned SPR_W   = 80,
  parameter int unsigned SPR_H   = 120,
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        x0,
  input  logic [6:0]        y0,
  input  logic [1:0]        sel,
  input  logic              player,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_q_r,
  input  logic              rom_q_s,
  input  logic              rom_q_p,
  output logic [7:0]        x,
  output logic [6:0]        y,
  output logic [2:0]        colour,
  output logic              plot,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CW = $clog2(SPR_W);
  localparam int unsigned RW = $clog2(SPR_H);
  localparam int unsigned FW = $clog2(ROM_LAT + 1);
  localparam int unsigned DW = 1 + 1 + 8 + 7;

  state_e        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [FW-1:0] flush_cnt;
  logic [7:0]    x0_l;
  logic [6:0]    y0_l;
  logic [1:0]    sel_l;
  logic          player_l;

  logic          last_col;
  logic          last_row;

  assign last_col = (col == CW'(SPR_W - 1));
  assign last_row = (row == RW'(SPR_H - 1));

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      flush_cnt <= '0;
      x0_l      <= '0;
      y0_l      <= '0;
      sel_l     <= '0;
      player_l  <= 1'b0;
      rom_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SCAN;
            x0_l     <= x0;
            y0_l     <= y0;
            sel_l    <= sel;
            player_l <= player;
            col      <= '0;
            row      <= '0;
            rom_addr <= '0;
            busy     <= 1'b1;
          end
        end
        SCAN: begin
          // Row-major scan makes the address a plain running count.
          if (last_col) begin
            col <= '0;
            if (last_row) begin
              state     <= FLUSH;
              flush_cnt <= '0;
            end else begin
              row      <= row + RW'(1);
              rom_addr <= rom_addr + ADDR_W'(1);
            end
          end else begin
            col      <= col + CW'(1);
            rom_addr <= rom_addr + ADDR_W'(1);
          end
        end
        FLUSH: begin
          if (flush_cnt == FW'(ROM_LAT - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [8:0]    sx;
  logic [7:0]    sy;
  logic          inbounds;
  logic [DW-1:0] head;
  logic [DW-1:0] tail;

  assign sx       = 9'(x0_l) + 9'(col);
  assign sy       = 8'(y0_l) + 8'(row);
  assign inbounds = (sx < 9'(SCR_W)) && (sy < 8'(SCR_H));
  assign head     = {(state == SCAN), inbounds, sx[7:0], sy[6:0]};

  rps_delay_line #(
    .LAT (ROM_LAT),
    .W   (DW)
  ) u_delay (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .d     (head),
    .q     (tail)
  );

  logic tail_valid;
  logic tail_inb;
  logic q;

  assign tail_valid = tail[DW-1];
  assign tail_inb   = tail[DW-2];
  assign x          = tail[14:7];
  assign y          = tail[6:0];

  always_comb begin
    case (sel_l)
      SEL_ROCK:    q = rom_q_r;
      SEL_SCISSOR: q = rom_q_s;
      default:     q = rom_q_p;
    endcase
  end

  always_comb begin
    colour = '0;
    if (tail_valid) colour = q ? (player_l ? COL_BG_CPU : COL_BG_USER) : COL_SPRITE;
  end

`ifdef SPRITE_TRANSPARENT_EN
  assign plot = tail_valid && tail_inb && !q;
`else
  assign plot = tail_valid && tail_inb;
`endif

endmodule
